// File: rtl/vga_sram_pixel_reader_pkg.sv
// Framebuffer geometry and pixel layout shared by the SRAM scan-out reader
// and the pattern writer.
package vga_sram_pixel_reader_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int FB_PIXELS = H_VISIBLE * V_VISIBLE;

    // RGB444 lives in the top 12 bits of each 16-bit word; [3:0] are unused.
    localparam int PIX_R_HI = 15;
    localparam int PIX_R_LO = 12;
    localparam int PIX_G_HI = 11;
    localparam int PIX_G_LO = 8;
    localparam int PIX_B_HI = 7;
    localparam int PIX_B_LO = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [3:0] pad;
    } rgb444_t;

    function automatic int unsigned fb_index(input int unsigned row, input int unsigned col);
        return row * H_VISIBLE + col;
    endfunction

endpackage

// File: rtl/vga_sram_pixel_reader_if.sv
// SRAM read-port and pixel-stream signals between the scan-out reader,
// the SRAM controller and the VGA output stage.
interface vga_sram_pixel_reader_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
);

    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_ready;
    logic                 rd_data_valid;
    logic [DATA_BITS-1:0] rd_data;
    logic                 pix_ready;
    logic                 pix_valid;
    logic [DATA_BITS-1:0] pix_data;

    // master is the pixel reader; slave is the controller plus VGA stage.
    modport master (
        output rd_req, rd_addr, pix_valid, pix_data,
        input  rd_ready, rd_data_valid, rd_data, pix_ready
    );

    modport slave (
        input  rd_req, rd_addr, pix_valid, pix_data,
        output rd_ready, rd_data_valid, rd_data, pix_ready
    );

endinterface

// File: rtl/vga_sram_pixel_reader_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count and a
// synchronous flush that overrides push and pop.
module vga_sram_pixel_reader_sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

    // Head reads as zero when empty so the pixel bus is clean out of reset.
    assign empty = (count_q == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/vga_sram_pixel_reader.sv
// Scan-out side of the SRAM framebuffer: credit-limited raster-order reads
// into a small prefetch FIFO feeding the VGA output stage.
module vga_sram_pixel_reader
    import vga_sram_pixel_reader_pkg::*;
#(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int FRAME_PIXELS = FB_PIXELS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    vga_sram_pixel_reader_if.master bus,
    output logic                    underflow,
    output logic                    frame_done
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int DISC_W = CNT_W + 2;
    localparam logic [ADDR_BITS-1:0] LAST_INDEX = ADDR_BITS'(FRAME_PIXELS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]           state;
    logic                 restart_hold;
    logic [ADDR_BITS-1:0] index;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     fifo_count;
    logic [DISC_W-1:0]    discard;
    logic [CNT_W:0]       credit_used;
    logic                 accept;
    logic                 ret_keep;
    logic                 pop;
    logic                 fifo_empty;

    // Credits only grow on accept, so rd_req cannot fall while waiting for rd_ready.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign bus.rd_req  = (state == ST_FETCH) && !restart_hold &&
                         (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign bus.rd_addr = index;
    assign accept      = bus.rd_req && bus.rd_ready;
    assign ret_keep    = bus.rd_data_valid && (discard == '0) && !frame_start;
    assign pop         = bus.pix_valid && bus.pix_ready && !frame_start;
    assign frame_done  = (state == ST_IDLE);
    assign bus.pix_valid = !fifo_empty;

    // restart_hold forces the one dead cycle after frame_start before address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            restart_hold <= 1'b0;
            index        <= '0;
        end else if (frame_start) begin
            state        <= ST_FETCH;
            restart_hold <= 1'b1;
            index        <= '0;
        end else begin
            restart_hold <= 1'b0;
            if (accept) begin
                if (index == LAST_INDEX)
                    state <= ST_IDLE;
                else
                    index <= index + ADDR_BITS'(1);
            end
        end
    end

    // Everything still in flight at frame_start is owed to the old frame and is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            discard     <= '0;
        end else if (frame_start) begin
            outstanding <= '0;
            discard     <= discard + DISC_W'(outstanding) + DISC_W'(accept)
                         - DISC_W'(bus.rd_data_valid && ((discard != '0) || (outstanding != '0)));
        end else begin
            if (bus.rd_data_valid && (discard != '0))
                discard <= discard - DISC_W'(1);
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(ret_keep);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underflow <= 1'b0;
        else if (bus.pix_ready && !bus.pix_valid && !frame_start)
            underflow <= 1'b1;
    end

    vga_sram_pixel_reader_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (frame_start),
        .push  (ret_keep),
        .wdata (bus.rd_data),
        .pop   (pop),
        .rdata (bus.pix_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_vga_sram_pixel_reader.sv
// Directed bench for the SRAM pixel reader: a controller model with fixed
// latency feeds a scoreboard of expected pixels, popped as the VGA side consumes.
module tb_vga_sram_pixel_reader;

    localparam int ADDR_BITS    = 20;
    localparam int DATA_BITS    = 16;
    localparam int FIFO_DEPTH   = 8;
    localparam int FRAME_PIXELS = 96;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    logic clk;
    logic reset;
    logic frame_start;
    logic underflow;
    logic frame_done;

    vga_sram_pixel_reader_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

    vga_sram_pixel_reader #(
        .ADDR_BITS    (ADDR_BITS),
        .DATA_BITS    (DATA_BITS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bus         (bus),
        .underflow   (underflow),
        .frame_done  (frame_done)
    );

    ret_t        pipe[$];
    logic [15:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int latency    = 1;
    int epoch      = 0;
    int exp_addr   = 0;
    int n_acc      = 0;
    int n_pop      = 0;
    bit active     = 0;
    bit done_next  = 0;
    bit rand_ready = 0;
    bit reached    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Data tagged with the frame epoch so words from a dropped frame are distinguishable.
    function automatic logic [15:0] fb_word(input int ep, input int addr);
        logic [31:0] e;
        logic [31:0] a;
        e = ep;
        a = addr;
        return {e[3:0], a[11:0]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, model the controller, score pops.
    task automatic apply_stimulus(input bit fs, input bit rdy, input bit pr);
        ret_t r;
        @(negedge clk);
        if (done_next) begin
            check_output("frame_done_after_last", 32'(frame_done), 32'd1);
            done_next = 0;
        end
        frame_start       = fs;
        bus.rd_ready      = rand_ready ? ($urandom_range(0, 1) == 1) : rdy;
        bus.pix_ready     = pr;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data       = pipe[0].data;
            void'(pipe.pop_front());
        end
        if (bus.rd_req && !active)
            check_output("req_when_idle", 32'(bus.rd_req), 32'd0);
        if (bus.rd_req && bus.rd_ready) begin
            check_output("rd_addr", 32'(bus.rd_addr), exp_addr);
            r.due  = cyc + latency;
            r.data = fb_word(epoch, exp_addr);
            pipe.push_back(r);
            if (!fs) begin
                exp_q.push_back(fb_word(epoch, exp_addr));
                n_acc++;
                if (exp_addr == FRAME_PIXELS - 1) begin
                    active    = 0;
                    done_next = 1;
                end
            end
            exp_addr++;
        end
        if (bus.pix_valid && pr && !fs) begin
            if (exp_q.size() == 0)
                check_output("pop_unexpected", 32'(bus.pix_valid), 32'd0);
            else
                check_output("pix_data", 32'(bus.pix_data), 32'(exp_q.pop_front()));
            n_pop++;
        end
        if (fs) begin
            exp_q.delete();
            exp_addr  = 0;
            epoch++;
            active    = 1;
            n_acc     = 0;
            n_pop     = 0;
            done_next = 0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        frame_start       = 1'b0;
        bus.rd_ready      = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        bus.pix_ready     = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_rd_req", 32'(bus.rd_req), 32'd0);
        check_output("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
        check_output("reset_pix_valid", 32'(bus.pix_valid), 32'd0);
        check_output("reset_pix_data", 32'(bus.pix_data), 32'd0);
        check_output("reset_underflow", 32'(underflow), 32'd0);
        check_output("reset_frame_done", 32'(frame_done), 32'd1);
        reset = 1'b0;
        pipe.delete();
        exp_q.delete();
        exp_addr  = 0;
        active    = 0;
        done_next = 0;
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        $display("[TB] idle after reset");
        repeat (20) apply_stimulus(0, 1, 0);
        check_output("idle_rd_req", 32'(bus.rd_req), 32'd0);
        check_output("idle_frame_done", 32'(frame_done), 32'd1);
        check_output("idle_pix_valid", 32'(bus.pix_valid), 32'd0);

        $display("[TB] prefetch fill with latency 2");
        latency = 2;
        apply_stimulus(1, 1, 0);
        apply_stimulus(0, 1, 0);
        check_output("start_frame_done", 32'(frame_done), 32'd0);
        check_output("start_dead_cycle", 32'(bus.rd_req), 32'd0);
        apply_stimulus(0, 1, 0);
        check_output("start_rd_req", 32'(bus.rd_req), 32'd1);
        check_output("start_rd_addr", 32'(bus.rd_addr), 32'd0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 0);
        check_output("pix0_not_yet", 32'(bus.pix_valid), 32'd0);
        apply_stimulus(0, 1, 0);
        check_output("pix0_valid", 32'(bus.pix_valid), 32'd1);
        check_output("pix0_data", 32'(bus.pix_data), 32'(fb_word(epoch, 0)));
        repeat (15) apply_stimulus(0, 1, 0);
        check_output("fill_requests", n_acc, FIFO_DEPTH);
        check_output("fill_rd_req", 32'(bus.rd_req), 32'd0);
        repeat (8) apply_stimulus(0, 0, 1);
        check_output("drain_pops", n_pop, 8);
        apply_stimulus(0, 0, 0);
        check_output("drain_empty", 32'(bus.pix_valid), 32'd0);
        check_output("no_underflow_yet", 32'(underflow), 32'd0);

        $display("[TB] back-pressure hold");
        repeat (10) begin
            apply_stimulus(0, 0, 0);
            check_output("bp_rd_req", 32'(bus.rd_req), 32'd1);
            check_output("bp_rd_addr", 32'(bus.rd_addr), 32'd8);
        end
        repeat (3) apply_stimulus(0, 1, 0);
        check_output("bp_requests", n_acc, 11);
        repeat (5) apply_stimulus(0, 0, 0);

        $display("[TB] underflow on empty FIFO");
        check_output("pre_underflow", 32'(underflow), 32'd0);
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            apply_stimulus(0, 0, 1);
            if (!bus.pix_valid)
                reached = 1;
        end
        check_output("drain_reached_empty", 32'(reached), 32'd1);
        apply_stimulus(0, 0, 0);
        check_output("underflow_set", 32'(underflow), 32'd1);

        $display("[TB] frame_start with three reads outstanding");
        latency = 3;
        apply_stimulus(1, 1, 0);
        repeat (4) apply_stimulus(0, 1, 0);
        check_output("outstanding_reqs", n_acc, 3);
        latency = 1;
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 1, 0);
        check_output("underflow_sticky", 32'(underflow), 32'd1);
        check_output("flushed", 32'(bus.pix_valid), 32'd0);
        reached = 0;
        for (int i = 0; i < 30 && !reached; i++) begin
            apply_stimulus(0, 1, 0);
            if (bus.pix_valid)
                reached = 1;
        end
        check_output("restart_pix_valid", 32'(reached), 32'd1);
        check_output("restart_first_pix", 32'(bus.pix_data), 32'(fb_word(epoch, 0)));
        repeat (6) apply_stimulus(0, 0, 1);

        $display("[TB] full frame with random rd_ready");
        latency    = 2;
        rand_ready = 1;
        apply_stimulus(1, 0, 0);
        repeat (12) apply_stimulus(0, 0, 0);
        for (int i = 0; i < 3000 && n_pop < FRAME_PIXELS; i++)
            apply_stimulus(0, 0, 1);
        rand_ready = 0;
        check_output("frame_pops", n_pop, FRAME_PIXELS);
        check_output("frame_requests", n_acc, FRAME_PIXELS);
        repeat (5) apply_stimulus(0, 1, 1);
        check_output("frame_done_end", 32'(frame_done), 32'd1);
        check_output("frame_rd_req_end", 32'(bus.rd_req), 32'd0);
        check_output("frame_fifo_empty", 32'(bus.pix_valid), 32'd0);
        check_output("underflow_still", 32'(underflow), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
